// File: rtl/main_fsm_pkg.sv
// Shared encodings for the multi-cycle control FSM: opcodes, state codes,
// mux-select and ALU/immediate control codings.
package main_fsm_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_e;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/main_fsm_if.sv
// Control bundle between the FSM (master) and the datapath (slave).
interface main_fsm_if;

    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_write;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] alu_op;
    logic [1:0] imm_src;
    logic       illegal_op;
    logic [3:0] state_o;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, ir_write, reg_write, mem_write, adr_src,
               alu_src_a, alu_src_b, result_src, alu_op, imm_src,
               illegal_op, state_o
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, ir_write, reg_write, mem_write, adr_src,
               alu_src_a, alu_src_b, result_src, alu_op, imm_src,
               illegal_op, state_o
    );

endinterface

// File: rtl/main_fsm_imm_src_decoder.sv
// Purely combinational opcode -> immediate-format select.
module imm_src_decoder
    import main_fsm_pkg::*;
(
    input  logic [6:0] opcode_i,
    output logic [1:0] imm_src_o
);

    assign imm_src_o = imm_src_of(opcode_i);

endmodule

// File: rtl/main_fsm.sv
// Multi-cycle RISC-V control FSM: Moore outputs per state, with fetch and
// memory states optionally stalled on mem_ready and a sticky illegal-op trap.
module main_fsm
    import main_fsm_pkg::*;
#(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter bit ENABLE_ITYPE  = 1'b1,
    parameter bit ENABLE_JAL    = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    main_fsm_if.master bus
);

    state_e     state_q, state_d;
    logic       illegal_q, illegal_d;
    logic       ready;
    logic       pc_write_en, ir_write_en, reg_write_en, mem_write_en;

    assign ready = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        pc_write_en    = 1'b0;
        ir_write_en    = 1'b0;
        reg_write_en   = 1'b0;
        mem_write_en   = 1'b0;
        bus.adr_src    = 1'b0;
        bus.alu_src_a  = SRCA_PC;
        bus.alu_src_b  = SRCB_RS2;
        bus.alu_op     = ALUOP_ADD;
        bus.result_src = RES_ALUOUT;
        case (state_q)
            S_FETCH: begin
                bus.alu_src_b  = SRCB_FOUR;
                bus.result_src = RES_ALU;
                pc_write_en    = ready;
                ir_write_en    = ready;
                if (ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                bus.alu_src_a = SRCA_OLDPC;
                bus.alu_src_b = SRCB_IMM;
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECR;
                    OP_ITYPE:     state_d = ENABLE_ITYPE ? S_EXECI : S_TRAP;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = ENABLE_JAL ? S_JAL : S_TRAP;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                bus.alu_src_a = SRCA_RS1;
                bus.alu_src_b = SRCB_IMM;
                state_d       = (bus.opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                bus.adr_src = 1'b1;
                if (ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                bus.result_src = RES_MEM;
                reg_write_en   = 1'b1;
                state_d        = S_FETCH;
            end
            S_MEMWRITE: begin
                bus.adr_src  = 1'b1;
                mem_write_en = 1'b1;
                if (ready) state_d = S_FETCH;
            end
            S_EXECR: begin
                bus.alu_src_a = SRCA_RS1;
                bus.alu_op    = ALUOP_FUNCT;
                state_d       = S_ALUWB;
            end
            S_EXECI: begin
                bus.alu_src_a = SRCA_RS1;
                bus.alu_src_b = SRCB_IMM;
                bus.alu_op    = ALUOP_FUNCT;
                state_d       = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_en = 1'b1;
                state_d      = S_FETCH;
            end
            S_BEQ: begin
                bus.alu_src_a = SRCA_RS1;
                bus.alu_op    = ALUOP_SUB;
                pc_write_en   = bus.zero;
                state_d       = S_FETCH;
            end
            S_JAL: begin
                bus.alu_src_a = SRCA_OLDPC;
                bus.alu_src_b = SRCB_FOUR;
                pc_write_en   = 1'b1;
                state_d       = S_ALUWB;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
        illegal_d = illegal_q | (state_d == S_TRAP);
    end

    // Enables are gated by rst_n so an asserted reset silences writes before any edge.
    assign bus.pc_write   = pc_write_en  & rst_n;
    assign bus.ir_write   = ir_write_en  & rst_n;
    assign bus.reg_write  = reg_write_en & rst_n;
    assign bus.mem_write  = mem_write_en & rst_n;
    assign bus.illegal_op = illegal_q;
    assign bus.state_o    = state_q;

    imm_src_decoder u_imm_src_decoder (
        .opcode_i  (bus.opcode),
        .imm_src_o (bus.imm_src)
    );

endmodule

// File: tb/tb_main_fsm.sv
// Directed bench: one instance with handshake and all opcodes enabled, one
// with handshake off and I-type/JAL disabled; per-cycle control-vector checks.
module tb_main_fsm;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    main_fsm_if ifa ();
    main_fsm_if ifb ();

    main_fsm #(.MEM_HANDSHAKE(1'b1), .ENABLE_ITYPE(1'b1), .ENABLE_JAL(1'b1)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa.master)
    );

    main_fsm #(.MEM_HANDSHAKE(1'b0), .ENABLE_ITYPE(1'b0), .ENABLE_JAL(1'b0)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

    // {state, pc_w, ir_w, reg_w, mem_w, adr_src, src_a, src_b, alu_op, result_src}
    localparam logic [16:0] E_RST  = {4'd0,  5'b00000, 8'b00_10_00_10};
    localparam logic [16:0] E_F1   = {4'd0,  5'b11000, 8'b00_10_00_10};
    localparam logic [16:0] E_F0   = {4'd0,  5'b00000, 8'b00_10_00_10};
    localparam logic [16:0] E_DEC  = {4'd1,  5'b00000, 8'b01_01_00_00};
    localparam logic [16:0] E_MADR = {4'd2,  5'b00000, 8'b10_01_00_00};
    localparam logic [16:0] E_MRD  = {4'd3,  5'b00001, 8'b00_00_00_00};
    localparam logic [16:0] E_MWB  = {4'd4,  5'b00100, 8'b00_00_00_01};
    localparam logic [16:0] E_MWR  = {4'd5,  5'b00011, 8'b00_00_00_00};
    localparam logic [16:0] E_EXR  = {4'd6,  5'b00000, 8'b10_00_10_00};
    localparam logic [16:0] E_EXI  = {4'd7,  5'b00000, 8'b10_01_10_00};
    localparam logic [16:0] E_AWB  = {4'd8,  5'b00100, 8'b00_00_00_00};
    localparam logic [16:0] E_BEQ1 = {4'd9,  5'b10000, 8'b10_00_01_00};
    localparam logic [16:0] E_BEQ0 = {4'd9,  5'b00000, 8'b10_00_01_00};
    localparam logic [16:0] E_JAL  = {4'd10, 5'b10000, 8'b01_10_00_00};
    localparam logic [16:0] E_TRAP = {4'd11, 5'b00000, 8'b00_00_00_00};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [16:0] obs_a();
        return {ifa.state_o, ifa.pc_write, ifa.ir_write, ifa.reg_write, ifa.mem_write,
                ifa.adr_src, ifa.alu_src_a, ifa.alu_src_b, ifa.alu_op, ifa.result_src};
    endfunction

    function automatic logic [16:0] obs_b();
        return {ifb.state_o, ifb.pc_write, ifb.ir_write, ifb.reg_write, ifb.mem_write,
                ifb.adr_src, ifb.alu_src_a, ifb.alu_src_b, ifb.alu_op, ifb.result_src};
    endfunction

    // Drive inputs, check the current state's outputs, then advance one clock.
    task automatic cyc(input string tag, input bit sel, input logic mr, input logic z,
                       input logic [16:0] exp);
        if (!sel) begin
            ifa.mem_ready = mr;
            ifa.zero      = z;
        end else begin
            ifb.zero = z;
        end
        #1;
        check_eq(tag, {15'd0, (sel ? obs_b() : obs_a())}, {15'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n         = 1'b0;
        ifa.opcode    = LW;
        ifa.mem_ready = 1'b1;
        ifa.zero      = 1'b0;
        ifb.opcode    = RT;
        ifb.mem_ready = 1'b0;
        ifb.zero      = 1'b0;
        #2;
        check_eq("rst_vec", {15'd0, obs_a()}, {15'd0, E_RST});
        check_eq("rst_illegal", 32'(ifa.illegal_op), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        check_eq("lw_imm", 32'(ifa.imm_src), 32'd0);
        cyc("lw_fetch", 0, 1, 0, E_F1);
        cyc("lw_dec",   0, 1, 0, E_DEC);
        cyc("lw_madr",  0, 1, 0, E_MADR);
        cyc("lw_mrd",   0, 1, 0, E_MRD);
        cyc("lw_mwb",   0, 1, 0, E_MWB);

        ifa.opcode = SW;
        #1 check_eq("sw_imm", 32'(ifa.imm_src), 32'd1);
        cyc("sw_fetch", 0, 1, 0, E_F1);
        cyc("sw_dec",   0, 1, 0, E_DEC);
        cyc("sw_madr",  0, 1, 0, E_MADR);
        for (int i = 0; i < 3; i++) cyc("sw_mwr_wait", 0, 0, 0, E_MWR);
        cyc("sw_mwr_done", 0, 1, 0, E_MWR);

        ifa.opcode = RT;
        cyc("r_fetch_wait", 0, 0, 0, E_F0);
        cyc("r_fetch", 0, 1, 0, E_F1);
        cyc("r_dec",   0, 1, 0, E_DEC);
        cyc("r_exec",  0, 1, 0, E_EXR);
        cyc("r_wb",    0, 1, 0, E_AWB);

        ifa.opcode = IT;
        cyc("i_fetch", 0, 1, 0, E_F1);
        cyc("i_dec",   0, 1, 0, E_DEC);
        cyc("i_exec",  0, 1, 0, E_EXI);
        cyc("i_wb",    0, 1, 0, E_AWB);

        ifa.opcode = BQ;
        #1 check_eq("beq_imm", 32'(ifa.imm_src), 32'd2);
        cyc("beq1_fetch", 0, 1, 1, E_F1);
        cyc("beq1_dec",   0, 1, 1, E_DEC);
        cyc("beq1_taken", 0, 1, 1, E_BEQ1);
        cyc("beq0_fetch", 0, 1, 0, E_F1);
        cyc("beq0_dec",   0, 1, 0, E_DEC);
        cyc("beq0_not",   0, 1, 0, E_BEQ0);

        ifa.opcode = JL;
        #1 check_eq("jal_imm", 32'(ifa.imm_src), 32'd3);
        cyc("jal_fetch", 0, 1, 0, E_F1);
        cyc("jal_dec",   0, 1, 0, E_DEC);
        cyc("jal_exec",  0, 1, 0, E_JAL);
        cyc("jal_wb",    0, 1, 0, E_AWB);

        ifa.opcode = LW;
        cyc("lww_fetch",    0, 1, 0, E_F1);
        cyc("lww_dec",      0, 1, 0, E_DEC);
        cyc("lww_madr",     0, 1, 0, E_MADR);
        cyc("lww_mrd_wait", 0, 0, 0, E_MRD);
        cyc("lww_mrd",      0, 1, 0, E_MRD);
        cyc("lww_mwb",      0, 1, 0, E_MWB);

        // Asynchronous reset while a store is writing.
        ifa.opcode = SW;
        cyc("swr_fetch", 0, 1, 0, E_F1);
        cyc("swr_dec",   0, 1, 0, E_DEC);
        cyc("swr_madr",  0, 1, 0, E_MADR);
        ifa.mem_ready = 1'b1;
        #1 check_eq("swr_mw_on", 32'(ifa.mem_write), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("swr_mw_off", 32'(ifa.mem_write), 32'd0);
        check_eq("swr_state", 32'(ifa.state_o), 32'd0);
        check_eq("swr_pcw_rst", 32'(ifa.pc_write), 32'd0);
        check_eq("swr_irw_rst", 32'(ifa.ir_write), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        ifa.opcode = 7'b0000000;
        cyc("ill_fetch", 0, 1, 0, E_F1);
        cyc("ill_dec",   0, 1, 0, E_DEC);
        for (int i = 0; i < 20; i++) begin
            cyc("ill_trap", 0, 1, 1, E_TRAP);
            check_eq("ill_flag", 32'(ifa.illegal_op), 32'd1);
        end
        rst_n = 1'b0;
        #1;
        check_eq("ill_rst_state", 32'(ifa.state_o), 32'd0);
        check_eq("ill_rst_flag", 32'(ifa.illegal_op), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc("ill_refetch", 0, 1, 0, E_F1);

        // No-handshake instance, mem_ready held low.
        reset_pulse();
        ifb.opcode = RT;
        cyc("b_r_fetch", 1, 0, 0, E_F1);
        cyc("b_r_dec",   1, 0, 0, E_DEC);
        cyc("b_r_exec",  1, 0, 0, E_EXR);
        cyc("b_r_wb",    1, 0, 0, E_AWB);
        ifb.opcode = LW;
        cyc("b_lw_fetch", 1, 0, 0, E_F1);
        cyc("b_lw_dec",   1, 0, 0, E_DEC);
        cyc("b_lw_madr",  1, 0, 0, E_MADR);
        cyc("b_lw_mrd",   1, 0, 0, E_MRD);
        cyc("b_lw_mwb",   1, 0, 0, E_MWB);
        ifb.opcode = SW;
        cyc("b_sw_fetch", 1, 0, 0, E_F1);
        cyc("b_sw_dec",   1, 0, 0, E_DEC);
        cyc("b_sw_madr",  1, 0, 0, E_MADR);
        cyc("b_sw_mwr",   1, 0, 0, E_MWR);
        ifb.opcode = JL;
        cyc("b_jal_fetch", 1, 0, 0, E_F1);
        cyc("b_jal_dec",   1, 0, 0, E_DEC);
        cyc("b_jal_trap",  1, 0, 0, E_TRAP);
        check_eq("b_jal_flag", 32'(ifb.illegal_op), 32'd1);
        reset_pulse();
        check_eq("b_rst_flag", 32'(ifb.illegal_op), 32'd0);
        ifb.opcode = IT;
        cyc("b_i_fetch", 1, 0, 0, E_F1);
        cyc("b_i_dec",   1, 0, 0, E_DEC);
        cyc("b_i_trap",  1, 0, 0, E_TRAP);
        check_eq("b_i_flag", 32'(ifb.illegal_op), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/main_fsm.md
MAIN_FSM -- requirements
Module: main_fsm

Interface
REQ-001 SHALL have parameters: MEM_HANDSHAKE, 1, 1 means wait on mem_ready and 0 means treat mem_ready as always 1; ENABLE_ITYPE, 1, accept opcode 0010011; ENABLE_JAL, 1, accept opcode 1101111.
REQ-002 SHALL have one clock and an asynchronous, active-low reset; ports in order: clk in 1 system clock; rst_n in 1 async active-low reset.
REQ-003 SHALL have inputs: opcode in 7 instr[6:0] from IR; zero in 1 ALU zero flag; mem_ready in 1 memory access complete this cycle.
REQ-004 SHALL have enable outputs: pc_write out 1; ir_write out 1; reg_write out 1; mem_write out 1; adr_src out 1 (0 = PC, 1 = ALU result register).
REQ-005 SHALL have mux-select outputs: alu_src_a out 2 (00 PC, 01 old PC, 10 rs1); alu_src_b out 2 (00 rs2, 01 imm, 10 const 4); result_src out 2 (00 ALUOut, 01 mem data, 10 ALU result).
REQ-006 SHALL have decode and status outputs: alu_op out 2 (same coding as single-cycle decoder); imm_src out 2; illegal_op out 1 (sticky); state_o out 4 (debug state code).

Function
REQ-007 SHALL be a Moore FSM; outputs SHALL depend on state only, except where gated by mem_ready or zero.
REQ-008 SHALL have states with codes: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10, TRAP=11.
REQ-009 FETCH SHALL drive adr_src=0, a=00, b=10, alu_op=00, result_src=10; pc_write=ir_write=mem_ready; advance to DECODE only when mem_ready=1, else hold.
REQ-010 DECODE SHALL drive a=01, b=01, alu_op=00, computing the branch target.
REQ-011 DECODE transitions SHALL be: lw/sw -> MEMADR; R -> EXECR; I -> EXECI; beq -> BEQ; jal -> JAL; any other opcode -> TRAP.
REQ-012 A disabled opcode (ENABLE_ITYPE or ENABLE_JAL = 0) SHALL be treated as illegal.
REQ-013 MEMADR SHALL drive a=10, b=01, alu_op=00; go to MEMREAD if lw, MEMWRITE if sw.
REQ-014 MEMREAD SHALL drive adr_src=1, result_src=00; hold until mem_ready, then go to MEMWB.
REQ-015 MEMWB SHALL drive result_src=01, reg_write=1; then go to FETCH.
REQ-016 MEMWRITE SHALL drive adr_src=1, result_src=00, mem_write=1 continuously until the mem_ready cycle inclusive; then go to FETCH.
REQ-017 EXECR SHALL drive a=10, b=00, alu_op=10; EXECI SHALL drive a=10, b=01, alu_op=10; both then go to ALUWB.
REQ-018 ALUWB SHALL drive result_src=00, reg_write=1; then go to FETCH.
REQ-019 BEQ SHALL drive a=10, b=00, alu_op=01, result_src=00, pc_write=zero; then go to FETCH.
REQ-020 JAL SHALL drive a=01, b=10, alu_op=00, result_src=00, pc_write=1; then go to ALUWB (rd = PC+4).
REQ-021 TRAP SHALL set illegal_op=1, drive all enables 0, and remain in TRAP until reset.
REQ-022 imm_src SHALL be combinational from opcode: lw/I 00, sw 01, beq 10, jal 11, others 00.
REQ-023 All outputs not listed for a state SHALL be 0.
REQ-024 With MEM_HANDSHAKE=0, FETCH, MEMREAD and MEMWRITE SHALL each last exactly 1 cycle.
REQ-025 CPI SHALL be: lw 5, sw 4, R/I 4, beq 3, jal 4, each with zero wait states.

Reset
REQ-026 rst_n low SHALL asynchronously force state=FETCH and illegal_op=0.
REQ-027 While rst_n is low, pc_write, ir_write, reg_write and mem_write SHALL be forced 0 regardless of mem_ready.
REQ-028 Reset asserted mid-instruction SHALL abandon that instruction with no further write enables.
REQ-029 After rst_n deassertion, the first rising edge SHALL evaluate FETCH normally.

Structure
REQ-030 A shared package SHALL hold the opcode constants, state enum/codes, and the alu_op, imm_src, src-select and result_src encodings.
REQ-031 The FSM SHALL instantiate one sub-module, imm_src_decoder (opcode -> imm_src); all else SHALL be in main_fsm.

Verification
REQ-032 lw, mem_ready always 1: states SHALL run 0,1,2,3,4,0; reg_write=1 only in cycle 5; result_src=01 in that cycle.
REQ-033 sw, mem_ready low 3 cycles in MEMWRITE: mem_write SHALL be high for 4 consecutive cycles, then FETCH; pc_write=0 throughout MEMWRITE.
REQ-034 beq with zero=1, then beq with zero=0: pc_write SHALL pulse in BEQ for the first and stay 0 for the second; both SHALL take 3 cycles.
REQ-035 opcode 0000000 (or jal with ENABLE_JAL=0): SHALL reach TRAP, illegal_op=1, all enables 0 for 20 cycles; rst_n pulse SHALL return to FETCH with illegal_op=0.
REQ-036 rst_n asserted asynchronously in MEMWRITE with mem_ready=1: mem_write SHALL drop immediately, state_o=0.
REQ-037 MEM_HANDSHAKE=0 with mem_ready tied 0: an R-type SHALL complete in 4 cycles, with reg_write in cycle 4.
